// File: rtl/bus_interconnect_if.sv
// Shared-bus signal bundle for bus_interconnect. The master modport is the
// fabric's view; the slave modport is the attached masters/slaves (bench) view.
interface bus_interconnect_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [3:0]        mReq_;
  logic [3:0]        mGrnt_;
  logic [ADDR_W-1:0] mAddr [4];
  logic [3:0]        mAs_;
  logic [3:0]        mRW;
  logic [DATA_W-1:0] mData [4];
  logic [ADDR_W-1:0] sAddr;
  logic              sAs_;
  logic              sRW;
  logic [DATA_W-1:0] sData;
  logic [7:0]        sCS_;
  logic [DATA_W-1:0] sRdData [8];
  logic [7:0]        sRdy_;
  logic [DATA_W-1:0] mRdData;
  logic              mRdy_;

  modport master (
    input  mReq_, mAddr, mAs_, mRW, mData, sRdData, sRdy_,
    output mGrnt_, sAddr, sAs_, sRW, sData, sCS_, mRdData, mRdy_
  );

  modport slave (
    output mReq_, mAddr, mAs_, mRW, mData, sRdData, sRdy_,
    input  mGrnt_, sAddr, sAs_, sRW, sData, sCS_, mRdData, mRdy_
  );
endinterface

// File: rtl/bus_interconnect.sv
// 4-master / 8-slave shared bus with round-robin arbitration and a 3-bit address decoder.
// Optional slave timeout enabled by defining BUS_TIMEOUT_EN.
module bus_interconnect #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_,
  bus_interconnect_if.master  bus
);

  logic [1:0]        owner_q, owner_d;
  logic [1:0]        cand;
  logic              found;
  logic [2:0]        sel;
  logic [DATA_W-1:0] sel_rd;
  logic              sel_rdy_;

  // Owner keeps the bus while requesting; otherwise scan owner+1..owner+3.
  always_comb begin
    owner_d = owner_q;
    found   = 1'b0;
    cand    = '0;
    if (bus.mReq_[owner_q]) begin
      for (int i = 1; i < 4; i++) begin
        cand = owner_q + 2'(i);
        if (!found && !bus.mReq_[cand]) begin
          owner_d = cand;
          found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_) owner_q <= 2'd0;
    else        owner_q <= owner_d;
  end

  assign bus.mGrnt_ = ~(4'b0001 << owner_q);
  assign bus.sAddr  = bus.mAddr[owner_q];
  assign bus.sAs_   = bus.mAs_[owner_q];
  assign bus.sRW    = bus.mRW[owner_q];
  assign bus.sData  = bus.mData[owner_q];

  // Decode ignores the strobe; slaves qualify their chip select with sAs_.
  assign sel      = bus.mAddr[owner_q][ADDR_W-1 -: 3];
  assign bus.sCS_ = ~(8'b0000_0001 << sel);
  assign sel_rd   = bus.sRdData[sel];
  assign sel_rdy_ = bus.sRdy_[sel];

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       tmo_hit;

  assign tmo_hit = (tmo_q == 8'hFF);

  always_comb begin
    tmo_d = tmo_q + 8'd1;
    if (bus.mAs_[owner_q] || !sel_rdy_ || (owner_d != owner_q) || tmo_hit) tmo_d = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset_) tmo_q <= 8'd0;
    else        tmo_q <= tmo_d;
  end

  // A hung slave is answered by the fabric with a zero-data ready pulse.
  assign bus.mRdy_   = sel_rdy_ & ~tmo_hit;
  assign bus.mRdData = tmo_hit ? '0 : sel_rd;
`else
  assign bus.mRdy_   = sel_rdy_;
  assign bus.mRdData = sel_rd;
`endif

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard bench for bus_interconnect: stimulus pushes expected bus state,
// a negedge monitor pops and compares.
module tb_bus_interconnect;

  typedef struct {
    string       name;
    logic [3:0]  grnt;
    logic [29:0] addr;
    logic [31:0] data;
    logic        as_;
    logic        rw;
    logic [7:0]  cs;
    logic [31:0] rdata;
    logic        rdy;
  } exp_t;

`ifdef BUS_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  localparam logic [29:0] A0 = 30'h0000_0010;
  localparam logic [29:0] A1 = 30'h0800_0020;
  localparam logic [29:0] A2 = 30'h1000_0030;
  localparam logic [29:0] A3 = 30'h1800_0040;

  logic clk = 1'b0;
  logic reset_;
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  bus_interconnect_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  bus_interconnect #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic push(input string n, input logic [3:0] g, input logic [29:0] a,
                      input logic [31:0] d, input logic as_, input logic rw,
                      input logic [7:0] cs, input logic [31:0] rd, input logic rdy);
    exp_t e;
    e.name = n; e.grnt = g; e.addr = a; e.data = d; e.as_ = as_; e.rw = rw;
    e.cs = cs; e.rdata = rd; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".grnt"},  64'(bus.mGrnt_),  64'(e.grnt));
      chk({e.name, ".addr"},  64'(bus.sAddr),   64'(e.addr));
      chk({e.name, ".data"},  64'(bus.sData),   64'(e.data));
      chk({e.name, ".as"},    64'(bus.sAs_),    64'(e.as_));
      chk({e.name, ".rw"},    64'(bus.sRW),     64'(e.rw));
      chk({e.name, ".cs"},    64'(bus.sCS_),    64'(e.cs));
      chk({e.name, ".rdata"}, 64'(bus.mRdData), 64'(e.rdata));
      chk({e.name, ".rdy"},   64'(bus.mRdy_),   64'(e.rdy));
    end
  end

  initial begin
    reset_     = 1'b1;
    bus.mReq_  = 4'hF;
    bus.mAs_   = 4'hF;
    bus.mRW    = 4'h0;
    bus.mAddr[0] = A0; bus.mAddr[1] = A1; bus.mAddr[2] = A2; bus.mAddr[3] = A3;
    for (int i = 0; i < 4; i++) bus.mData[i] = 32'hD000_0000 + 32'(i);
    for (int j = 0; j < 8; j++) bus.sRdData[j] = 32'h5000_0000 + 32'(j);
    bus.sRdy_  = 8'hFF;

    step(); step();
    push("reset", 4'b1110, A0, 32'hD000_0000, 1'b1, 1'b0, 8'hFE, 32'h5000_0000, 1'b1);

    // m2 requests while m0 idles: one cycle of latency, then m2 owns the bus
    step(); reset_ = 1'b0; bus.mReq_ = 4'b1011;
    push("t2_latency", 4'b1110, A0, 32'hD000_0000, 1'b1, 1'b0, 8'hFE, 32'h5000_0000, 1'b1);
    step();
    push("t2_grant", 4'b1011, A2, 32'hD000_0002, 1'b1, 1'b0, 8'hFB, 32'h5000_0002, 1'b1);
    step(); bus.mReq_ = 4'b1110;
    push("t3_pre", 4'b1011, A2, 32'hD000_0002, 1'b1, 1'b0, 8'hFB, 32'h5000_0002, 1'b1);
    step(); bus.mReq_ = 4'b1100;
    push("t3_own0", 4'b1110, A0, 32'hD000_0000, 1'b1, 1'b0, 8'hFE, 32'h5000_0000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      push("t3_hold", 4'b1110, A0, 32'hD000_0000, 1'b1, 1'b0, 8'hFE, 32'h5000_0000, 1'b1);
    end
    step(); bus.mReq_ = 4'b1101;
    push("t3_release", 4'b1110, A0, 32'hD000_0000, 1'b1, 1'b0, 8'hFE, 32'h5000_0000, 1'b1);
    step(); bus.mReq_ = 4'b0110;
    push("t3_m1", 4'b1101, A1, 32'hD000_0001, 1'b1, 1'b0, 8'hFD, 32'h5000_0001, 1'b1);
    step(); bus.mReq_ = 4'hF;
    push("t4_rr", 4'b0111, A3, 32'hD000_0003, 1'b1, 1'b0, 8'hF7, 32'h5000_0003, 1'b1);
    step(); bus.mAddr[0] = 30'h3FFF_FFFF;
    push("t4_park", 4'b0111, A3, 32'hD000_0003, 1'b1, 1'b0, 8'hF7, 32'h5000_0003, 1'b1);

    // read from GPIO on slave 4, then the top slave 7
    step();
    bus.mAddr[3] = 30'h2000_0000; bus.mAs_ = 4'b0111; bus.mRW = 4'b1000;
    bus.sRdData[4] = 32'h0000_000F; bus.sRdy_ = 8'hEF;
    push("t5_s4", 4'b0111, 30'h2000_0000, 32'hD000_0003, 1'b0, 1'b1, 8'hEF, 32'h0000_000F, 1'b0);
    step(); bus.mAddr[3] = 30'h3FFF_FFFF; bus.sRdy_ = 8'h6F;
    push("t5_s7", 4'b0111, 30'h3FFF_FFFF, 32'hD000_0003, 1'b0, 1'b1, 8'h7F, 32'h5000_0007, 1'b0);

    // slave 5 never answers
    step(); bus.mAddr[3] = 30'h2800_0000; bus.sRdy_ = 8'hFF;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) step();
      push("t6_tmo", 4'b0111, 30'h2800_0000, 32'hD000_0003, 1'b0, 1'b1, 8'hDF,
           (TMO && c == 255) ? 32'h0 : 32'h5000_0005, (TMO && c == 255) ? 1'b0 : 1'b1);
    end

    // reset in the middle of the stalled transfer
    step(); reset_ = 1'b1;
    push("rst_pre", 4'b0111, 30'h2800_0000, 32'hD000_0003, 1'b0, 1'b1, 8'hDF, 32'h5000_0005, 1'b1);
    step(); reset_ = 1'b0; bus.mAs_ = 4'hF; bus.mRW = 4'h0;
    push("rst_mid", 4'b1110, 30'h3FFF_FFFF, 32'hD000_0000, 1'b1, 1'b0, 8'h7F, 32'h5000_0007, 1'b1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
